// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32 control sequencer: FETCH/DECODE/EXEC/MEM/WB/BRANCH with a
// memory-ready timeout and a sticky HALT carrying a fault code.
//
// state  | meaning
// FETCH  | read instruction at PC; load IR and PC+4 when memory is ready
// DECODE | classify opcode from IR; illegal encodings go to HALT
// EXEC   | ALU operation (funct-decoded for R, address add for LOAD/STORE)
// MEM    | data access at ALU address, held until memory is ready
// WB     | single-cycle register file write
// BRANCH | compare via ALU subtract, conditionally load branch target
// HALT   | stopped with fault code; only reset leaves
module multicycle_control_fsm #(
  parameter logic [6:0] OP_R      = 7'd51,
  parameter logic [6:0] OP_LOAD   = 7'd3,
  parameter logic [6:0] OP_STORE  = 7'd35,
  parameter logic [6:0] OP_BRANCH = 7'd99,
  parameter int         TIMEOUT   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        mem_ready_i,
  input  logic        alu_zero_i,
  output logic        pc_write_o,
  output logic        pc_src_o,
  output logic        ir_write_o,
  output logic        i_or_d_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        reg_write_o,
  output logic        mem_to_reg_o,
  output logic [1:0]  alu_op_o,
  output logic [2:0]  state_out_o,
  output logic        halted_o,
  output logic [1:0]  fault_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    C_R      = 2'd0,
    C_LOAD   = 2'd1,
    C_STORE  = 2'd2,
    C_BRANCH = 2'd3
  } class_t;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  state_t          state_q, state_d;
  class_t          class_q, class_d;
  logic [1:0]      fault_q, fault_d;
  logic [CW-1:0]   wait_q, wait_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instr_bits;

  assign opcode            = instr_i[6:0];
  assign funct3            = instr_i[14:12];
  assign unused_instr_bits = ^{instr_i[31:15], instr_i[11:7]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      class_q <= C_R;
      fault_q <= FAULT_NONE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      fault_q <= fault_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    fault_d      = fault_q;
    wait_d       = '0;
    pc_write_o   = 1'b0;
    pc_src_o     = 1'b0;
    ir_write_o   = 1'b0;
    i_or_d_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_op_o     = 2'b00;
    halted_o     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          fault_d = FAULT_TIMEOUT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (opcode == OP_R) begin
          class_d = C_R;
          state_d = S_EXEC;
        end else if (opcode == OP_LOAD) begin
          class_d = C_LOAD;
          state_d = S_EXEC;
        end else if (opcode == OP_STORE) begin
          class_d = C_STORE;
          state_d = S_EXEC;
        end else if (opcode == OP_BRANCH && funct3[2:1] == 2'b00) begin
          class_d = C_BRANCH;
          state_d = S_BRANCH;
        end else begin
          state_d = S_HALT;
          fault_d = FAULT_ILLEGAL;
        end
      end
      S_EXEC: begin
        alu_op_o = (class_q == C_R) ? 2'b10 : 2'b00;
        state_d  = (class_q == C_R) ? S_WB : S_MEM;
      end
      S_MEM: begin
        i_or_d_o    = 1'b1;
        mem_read_o  = (class_q == C_LOAD);
        mem_write_o = (class_q == C_STORE);
        if (mem_ready_i) begin
          state_d = (class_q == C_LOAD) ? S_WB : S_FETCH;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          fault_d = FAULT_TIMEOUT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = (class_q == C_LOAD);
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_op_o   = 2'b01;
        pc_src_o   = 1'b1;
        pc_write_o = (funct3 == 3'b000) ? alu_zero_i : ~alu_zero_i;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halted_o = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // A PC or IR load during reset would corrupt the restarted fetch.
    if (rst_i) begin
      pc_write_o = 1'b0;
      ir_write_o = 1'b0;
    end
  end

  assign state_out_o = state_q;
  assign fault_o     = fault_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: randomized instruction streams compared cycle by cycle
// against an instruction-level model of the expected control outputs.
module tb_multicycle_control_fsm;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        mem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic        pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write;
  logic        reg_write, mem_to_reg, halted;
  logic [1:0]  alu_op, fault;
  logic [2:0]  state_out;
  logic [15:0] act;

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .mem_ready_i(mem_ready),
    .alu_zero_i(alu_zero), .pc_write_o(pc_write), .pc_src_o(pc_src),
    .ir_write_o(ir_write), .i_or_d_o(i_or_d), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .reg_write_o(reg_write), .mem_to_reg_o(mem_to_reg),
    .alu_op_o(alu_op), .state_out_o(state_out), .halted_o(halted), .fault_o(fault)
  );

  always #5 clk = ~clk;

  // {state, pcw, pcs, irw, iod, mr, mw, rw, mtr, alu_op, halted, fault}
  assign act = {state_out, pc_write, pc_src, ir_write, i_or_d, mem_read,
                mem_write, reg_write, mem_to_reg, alu_op, halted, fault};

  function automatic logic [15:0] ev(input logic [2:0] st, input logic [7:0] strb,
                                     input logic [1:0] aop, input logic h,
                                     input logic [1:0] f);
    return {st, strb, aop, h, f};
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] r;
    r        = $urandom;
    r[6:0]   = op;
    r[14:12] = f3;
    return r;
  endfunction

  task automatic step(input logic [15:0] exp, input string nm);
    @(negedge clk);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic halt_cycles(input int n, input logic [1:0] f, input string nm);
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom);
      alu_zero  = 1'($urandom);
      instr     = $urandom;
      step(ev(3'd7, 8'b0, 2'b00, 1'b1, f), nm);
    end
  endtask

  // Instruction-level model: expected outputs for each cycle of one instruction,
  // given wf/wm not-ready cycles in fetch/memory (>= TO means a timeout).
  task automatic run_instr(input logic [31:0] ins, input int wf, input int wm,
                           input logic az, input bit abort_mem);
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    for (int i = 0; i < ((wf >= TO) ? TO : wf); i++) begin
      instr = $urandom;
      mem_ready = 1'b0;
      step(ev(3'd0, 8'b0000_1000, 2'b00, 1'b0, 2'b00), "fetch_wait");
    end
    if (wf >= TO) begin
      halt_cycles(3, 2'b10, "fetch_timeout_halt");
      return;
    end
    mem_ready = 1'b1;
    step(ev(3'd0, 8'b1010_1000, 2'b00, 1'b0, 2'b00), "fetch_ready");
    instr = ins;
    mem_ready = 1'($urandom);
    step(ev(3'd1, 8'b0, 2'b00, 1'b0, 2'b00), "decode");
    if (op == 7'd51) begin
      instr = $urandom;
      step(ev(3'd2, 8'b0, 2'b10, 1'b0, 2'b00), "r_exec");
      step(ev(3'd4, 8'b0000_0010, 2'b00, 1'b0, 2'b00), "r_wb");
    end else if (op == 7'd3 || op == 7'd35) begin
      logic [7:0] mstrb;
      mstrb = (op == 7'd3) ? 8'b0001_1000 : 8'b0001_0100;
      instr = $urandom;
      mem_ready = 1'($urandom);
      step(ev(3'd2, 8'b0, 2'b00, 1'b0, 2'b00), "ls_exec");
      for (int i = 0; i < ((wm >= TO) ? TO : wm); i++) begin
        mem_ready = 1'b0;
        instr = $urandom;
        if (abort_mem) begin
          rst = 1'b1;
          step(ev(3'd3, mstrb, 2'b00, 1'b0, 2'b00), "mem_at_reset");
          rst = 1'b0;
          step(ev(3'd0, 8'b0000_1000, 2'b00, 1'b0, 2'b00), "after_reset_mid_mem");
          return;
        end
        step(ev(3'd3, mstrb, 2'b00, 1'b0, 2'b00), "mem_wait");
      end
      if (wm >= TO) begin
        halt_cycles(3, 2'b10, "mem_timeout_halt");
        return;
      end
      mem_ready = 1'b1;
      step(ev(3'd3, mstrb, 2'b00, 1'b0, 2'b00), "mem_ready");
      if (op == 7'd3) begin
        mem_ready = 1'($urandom);
        step(ev(3'd4, 8'b0000_0011, 2'b00, 1'b0, 2'b00), "load_wb");
      end
    end else if (op == 7'd99 && f3 < 3'd2) begin
      logic taken;
      taken = (f3 == 3'b000) ? az : ~az;
      alu_zero = az;
      mem_ready = 1'($urandom);
      step(ev(3'd5, {taken, 1'b1, 6'b0}, 2'b01, 1'b0, 2'b00), "branch");
    end else begin
      halt_cycles(20, 2'b01, "illegal_halt");
    end
  endtask

  task automatic test_reset();
    apply_reset();
    step(ev(3'd0, 8'b0000_1000, 2'b00, 1'b0, 2'b00), "reset_state");
    rst = 1'b1;
    mem_ready = 1'b1;
    step(ev(3'd0, 8'b0000_1000, 2'b00, 1'b0, 2'b00), "strobes_masked_in_reset");
    rst = 1'b0;
    mem_ready = 1'b0;
    step(ev(3'd0, 8'b0000_1000, 2'b00, 1'b0, 2'b00), "fetch_after_reset");
  endtask

  task automatic test_directed();
    run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);
    run_instr(32'h0000A183, 0, 3, 1'b0, 1'b0);
    run_instr(32'h0020A023, 0, 0, 1'b0, 1'b0);
    run_instr(32'h00208463, 0, 0, 1'b1, 1'b0);
    run_instr(32'h00208463, 0, 0, 1'b0, 1'b0);
    run_instr(32'h00209463, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_illegal();
    run_instr(32'h00000013, 0, 0, 1'b0, 1'b0);
    apply_reset();
    step(ev(3'd0, 8'b0000_1000, 2'b00, 1'b0, 2'b00), "illegal_reset_exit");
    run_instr(mk(7'd99, 3'b100), 0, 0, 1'b0, 1'b0);
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      logic [6:0] op;
      op = 7'($urandom);
      if (op == 7'd51 || op == 7'd3 || op == 7'd35 || op == 7'd99) op = 7'd19;
      run_instr(mk(op, 3'($urandom)), $urandom_range(0, 2), 0, 1'b0, 1'b0);
      apply_reset();
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    run_instr(32'h002081B3, TO, 0, 1'b0, 1'b0);
    apply_reset();
    run_instr(32'h002081B3, TO - 1, 0, 1'b0, 1'b0);
    run_instr(32'h0000A183, 0, TO - 1, 1'b0, 1'b0);
    run_instr(32'h0020A023, 0, TO, 1'b0, 1'b0);
    apply_reset();
  endtask

  task automatic test_reset_mid_store();
    apply_reset();
    run_instr(32'h0020A023, 0, 2, 1'b0, 1'b1);
    run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ins;
      case ($urandom_range(0, 4))
        0: ins = mk(7'd51, 3'($urandom));
        1: ins = mk(7'd3, 3'($urandom));
        2: ins = mk(7'd35, 3'($urandom));
        3: ins = mk(7'd99, 3'b000);
        default: ins = mk(7'd99, 3'b001);
      endcase
      run_instr(ins, $urandom_range(0, 4), $urandom_range(0, 4),
                1'($urandom), 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_timeout();
    test_reset_mid_store();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
